// File: rtl/mult_pkg.sv
// Shared constants and helpers for the shift-and-add multiplier datapath.
package mult_pkg;

    localparam int MULT_N = 8;

    // Bits needed to count 0..n-1 (ceil(log2 n)), never less than one.
    function automatic int cnt_width(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/mult_adder.sv
// N-bit unsigned adder with carry-out; adds the multiplicand into the accumulator upper half.
module mult_adder
    import mult_pkg::*;
#(
    parameter int N = MULT_N
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] sum,
    output logic         carry
);

    assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/mult_datapath.sv
// Shift-and-add multiplier datapath: accumulator, multiplicand register and shift counter,
// sequenced externally through Load / Ad / Sh.
module mult_datapath
    import mult_pkg::*;
#(
    parameter int N = MULT_N
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic           Load,
    input  logic           Sh,
    input  logic           Ad,
    input  logic [N-1:0]   Mcand,
    input  logic [N-1:0]   Mplier,
    output logic           M,
    output logic           K,
    output logic [2*N-1:0] Product
);

    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    logic [2*N:0]  acc;
    logic [N-1:0]  mcr;
    logic [CW-1:0] cnt;

    logic [N-1:0]  sum;
    logic          carry;
    logic [2*N:0]  added;
    logic [2*N:0]  acc_next;
    logic [CW-1:0] cnt_inc;

    mult_adder #(.N(N)) u_adder (
        .a     (acc[2*N-1:N]),
        .b     (mcr),
        .sum   (sum),
        .carry (carry)
    );

    // Add happens before shift so Ad+Sh in one cycle equals add then shift.
    always_comb begin
        added = acc;
        if (Ad) begin
            added = {carry, sum, acc[N-1:0]};
        end
        acc_next = added;
        if (Sh) begin
            acc_next = {1'b0, added[2*N:1]};
        end
    end

    // Explicit wrap at N-1 keeps non-power-of-two widths cycling over 0..N-1.
    assign cnt_inc = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            acc <= '0;
            mcr <= '0;
            cnt <= '0;
        end else if (Load) begin
            acc <= {1'b0, {N{1'b0}}, Mplier};
            mcr <= Mcand;
            cnt <= '0;
        end else begin
            acc <= acc_next;
            if (Sh) begin
                cnt <= cnt_inc;
            end
        end
    end

    assign M       = acc[0];
    assign K       = (cnt == CNT_LAST);
    assign Product = acc[2*N-1:0];

endmodule
